// File: rtl/branch_history_predictor_pkg.sv
// Shared types for the fetch-stage BTB predictor and EX resolution checker.
// Branch type codes, counter encodings and table defaults.
package branch_history_predictor_pkg;

  localparam int DEF_ENTRIES    = 64;
  localparam int DEF_INDEX_BITS = 6;

  typedef enum logic [2:0] {
    NOBRANCH = 3'd0,
    BEQ      = 3'd1,
    BNE      = 3'd2,
    BLT      = 3'd3,
    BLTU     = 3'd4,
    BGE      = 3'd5,
    BGEU     = 3'd6
  } br_type_e;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/branch_history_predictor_if.sv
// Predictor bus: IF lookup, EX resolution and performance counters.
// master = pipeline side, slave = predictor.
interface branch_history_predictor_if;

  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic [31:0] PCE;
  logic [2:0]  BranchTypeE;
  logic        BranchE;
  logic [31:0] BranchTargetE;
  logic        PredTakenE;
  logic [31:0] PredTargetE;
  logic        StallE;
  logic        MispredictE;
  logic [31:0] RedirectPCE;
  logic [31:0] BranchCnt;
  logic [31:0] MispredCnt;

  modport master (
    output PCF, PCE, BranchTypeE, BranchE,
    output BranchTargetE, PredTakenE,
    output PredTargetE, StallE,
    input  PredTakenF, PredTargetF,
    input  MispredictE, RedirectPCE,
    input  BranchCnt, MispredCnt
  );

  modport slave (
    input  PCF, PCE, BranchTypeE, BranchE,
    input  BranchTargetE, PredTakenE,
    input  PredTargetE, StallE,
    output PredTakenF, PredTargetF,
    output MispredictE, RedirectPCE,
    output BranchCnt, MispredCnt
  );

endinterface

// File: rtl/branch_history_predictor_sat_counter2.sv
// 2-bit saturating counter next-state function.
// Pure combinational; saturates at SNT and ST.
module sat_counter2
  import branch_history_predictor_pkg::*;
(
  input  logic [1:0] state,
  input  logic       taken,
  output logic [1:0] next
);

  always_comb begin
    next = state;
    unique case (1'b1)
      taken  && (state != ST):  next = state + 2'd1;
      !taken && (state != SNT): next = state - 2'd1;
      default:                  next = state;
    endcase
  end

endmodule

// File: rtl/branch_history_predictor.sv
// Direct-mapped BTB with 2-bit counters: IF lookup, EX check and training.
// Lookup reads pre-edge contents; updates become visible the next cycle.
module branch_history_predictor
  import branch_history_predictor_pkg::*;
#(
  parameter int ENTRIES    = DEF_ENTRIES,
  parameter int INDEX_BITS = DEF_INDEX_BITS
) (
  input logic                      clk,
  input logic                      rst_n,
  branch_history_predictor_if.slave bus
);

  localparam int TW = 30 - INDEX_BITS;

  logic          valid_q  [ENTRIES];
  logic [TW-1:0] tag_q    [ENTRIES];
  logic [31:0]   target_q [ENTRIES];
  logic [1:0]    ctr_q    [ENTRIES];

  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  logic [INDEX_BITS-1:0] fidx;
  logic [TW-1:0]         ftag;
  logic                  fhit;
  logic                  ftaken;

  assign fidx   = bus.PCF[INDEX_BITS+1:2];
  assign ftag   = bus.PCF[31:INDEX_BITS+2];
  assign fhit   = valid_q[fidx] && (tag_q[fidx] == ftag);
  assign ftaken = fhit && ctr_q[fidx][1];

  assign bus.PredTakenF  = ftaken;
  assign bus.PredTargetF = ftaken ? target_q[fidx]
                                  : pc_plus4(bus.PCF);

  logic [INDEX_BITS-1:0] eidx;
  logic [TW-1:0]         etag;
  logic                  ehit;
  logic                  upd;
  logic                  mis;
  logic [1:0]            ctr_nxt;

  assign eidx = bus.PCE[INDEX_BITS+1:2];
  assign etag = bus.PCE[31:INDEX_BITS+2];
  assign ehit = valid_q[eidx] && (tag_q[eidx] == etag);
  assign upd  = (bus.BranchTypeE != NOBRANCH) && !bus.StallE;

  // Wrong direction, or right direction but stale target.
  assign mis = upd && ((bus.PredTakenE != bus.BranchE) ||
                       (bus.PredTakenE && bus.BranchE &&
                        (bus.PredTargetE != bus.BranchTargetE)));

  assign bus.MispredictE = mis;
  assign bus.RedirectPCE = bus.BranchE ? bus.BranchTargetE
                                       : pc_plus4(bus.PCE);
  assign bus.BranchCnt   = branch_cnt;
  assign bus.MispredCnt  = mispred_cnt;

  sat_counter2 u_ctr (
    .state (ctr_q[eidx]),
    .taken (bus.BranchE),
    .next  (ctr_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= SNT;
      end
    end else if (upd) begin
      if (ehit) begin
        ctr_q[eidx] <= ctr_nxt;
        if (bus.BranchE) target_q[eidx] <= bus.BranchTargetE;
      end else if (bus.BranchE) begin
        // Taken miss allocates and evicts whatever aliased here.
        valid_q[eidx]  <= 1'b1;
        tag_q[eidx]    <= etag;
        target_q[eidx] <= bus.BranchTargetE;
        ctr_q[eidx]    <= WT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (upd && (branch_cnt != '1))
        branch_cnt <= branch_cnt + 32'd1;
      if (mis && (mispred_cnt != '1))
        mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_history_predictor.sv
// Self-checking bench for branch_history_predictor.
// Vector table plus scoreboard queue, with reset and saturation sequences.
module tb_branch_history_predictor;

  logic clk;
  logic rst_n;

  branch_history_predictor_if bus ();

  branch_history_predictor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pcf;
    logic [2:0]  bt;
    logic        be;
    logic [31:0] bte;
    logic        pte;
    logic [31:0] ptge;
    logic [31:0] pce;
    logic        st;
    logic        xpt;
    logic [31:0] xptg;
    logic        xmis;
    logic [31:0] xred;
    logic [31:0] xbc;
    logic [31:0] xmc;
  } vec_t;

  vec_t vecs[$];
  vec_t sbq[$];

  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(
    input logic [31:0] pcf, input logic [2:0] bt,
    input logic be, input logic [31:0] bte,
    input logic pte, input logic [31:0] ptge,
    input logic [31:0] pce, input logic st,
    input logic xpt, input logic [31:0] xptg,
    input logic xmis, input logic [31:0] xred,
    input logic [31:0] xbc, input logic [31:0] xmc);
    vec_t v;
    v.pcf = pcf; v.bt = bt; v.be = be; v.bte = bte;
    v.pte = pte; v.ptge = ptge; v.pce = pce; v.st = st;
    v.xpt = xpt; v.xptg = xptg; v.xmis = xmis;
    v.xred = xred; v.xbc = xbc; v.xmc = xmc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.PCF           = v.pcf;
    bus.BranchTypeE   = v.bt;
    bus.BranchE       = v.be;
    bus.BranchTargetE = v.bte;
    bus.PredTakenE    = v.pte;
    bus.PredTargetE   = v.ptge;
    bus.PCE           = v.pce;
    bus.StallE        = v.st;
  endtask

  // Drive after posedge, push expectation, pop and compare at negedge.
  task automatic apply(input vec_t v, input int n);
    vec_t e;
    @(posedge clk);
    #1;
    drive(v);
    sbq.push_back(v);
    @(negedge clk);
    e = sbq.pop_front();
    chk($sformatf("v%0d PredTakenF", n), 32'(bus.PredTakenF), 32'(e.xpt));
    chk($sformatf("v%0d PredTargetF", n), bus.PredTargetF, e.xptg);
    chk($sformatf("v%0d MispredictE", n), 32'(bus.MispredictE), 32'(e.xmis));
    chk($sformatf("v%0d RedirectPCE", n), bus.RedirectPCE, e.xred);
    chk($sformatf("v%0d BranchCnt", n), bus.BranchCnt, e.xbc);
    chk($sformatf("v%0d MispredCnt", n), bus.MispredCnt, e.xmc);
  endtask

  localparam logic [2:0] NB  = 3'd0;
  localparam logic [2:0] BQ  = 3'd1;
  localparam logic [2:0] BN  = 3'd2;

  initial begin
    rst_n = 1'b0;
    drive(mk(0, NB, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // pcf bt be bte pte ptge pce st | pt ptg mis red bc mc
    vecs.push_back(mk(32'h100, NB, 0, 0, 0, 0, 0, 0,
                      0, 32'h104, 0, 32'h4, 0, 0));
    vecs.push_back(mk(32'h100, BQ, 1, 32'h80, 0, 32'h104, 32'h100, 0,
                      0, 32'h104, 1, 32'h80, 0, 0));
    vecs.push_back(mk(32'h100, BQ, 0, 32'h80, 1, 32'h80, 32'h100, 0,
                      1, 32'h80, 1, 32'h104, 1, 1));
    vecs.push_back(mk(32'h100, BQ, 0, 32'h80, 0, 32'h104, 32'h100, 0,
                      0, 32'h104, 0, 32'h104, 2, 2));
    vecs.push_back(mk(32'h200, NB, 0, 0, 0, 0, 0, 0,
                      0, 32'h204, 0, 32'h4, 3, 2));
    vecs.push_back(mk(32'h100, BQ, 1, 32'h80, 0, 32'h104, 32'h100, 0,
                      0, 32'h104, 1, 32'h80, 3, 2));
    vecs.push_back(mk(32'h100, BQ, 1, 32'h80, 0, 32'h104, 32'h100, 0,
                      0, 32'h104, 1, 32'h80, 4, 3));
    vecs.push_back(mk(32'h100, BQ, 1, 32'h80, 1, 32'h80, 32'h100, 0,
                      1, 32'h80, 0, 32'h80, 5, 4));
    vecs.push_back(mk(32'h100, BQ, 1, 32'h90, 1, 32'h80, 32'h100, 0,
                      1, 32'h80, 1, 32'h90, 6, 4));
    vecs.push_back(mk(32'h100, NB, 0, 0, 0, 0, 0, 0,
                      1, 32'h90, 0, 32'h4, 7, 5));
    vecs.push_back(mk(32'h100, BN, 1, 32'h300, 0, 32'h204, 32'h200, 0,
                      1, 32'h90, 1, 32'h300, 7, 5));
    vecs.push_back(mk(32'h100, NB, 0, 0, 0, 0, 0, 0,
                      0, 32'h104, 0, 32'h4, 8, 6));
    vecs.push_back(mk(32'h200, NB, 0, 0, 0, 0, 0, 0,
                      1, 32'h300, 0, 32'h4, 8, 6));
    vecs.push_back(mk(32'h200, BQ, 0, 32'h300, 1, 32'h300, 32'h200, 0,
                      1, 32'h300, 1, 32'h204, 8, 6));
    vecs.push_back(mk(32'h200, NB, 0, 0, 0, 0, 0, 0,
                      0, 32'h204, 0, 32'h4, 9, 7));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(32'h200, BN, 1, 32'h400, 0, 32'h204, 32'h200, 1,
                        0, 32'h204, 0, 32'h400, 9, 7));
    vecs.push_back(mk(32'h200, NB, 0, 0, 0, 0, 0, 0,
                      0, 32'h204, 0, 32'h4, 9, 7));
    vecs.push_back(mk(32'hFFFF_FFFC, NB, 0, 0, 0, 0, 32'hFFFF_FFFC, 0,
                      0, 32'h0, 0, 32'h0, 9, 7));
    vecs.push_back(mk(32'h300, NB, 1, 32'h500, 0, 32'h304, 32'h300, 0,
                      0, 32'h304, 0, 32'h500, 9, 7));
    vecs.push_back(mk(32'h300, NB, 0, 0, 0, 0, 0, 0,
                      0, 32'h304, 0, 32'h4, 9, 7));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Preload both counters just below saturation.
    force dut.branch_cnt  = 32'hFFFF_FFFE;
    force dut.mispred_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.branch_cnt;
    release dut.mispred_cnt;
    apply(mk(32'h40, BQ, 1, 32'h800, 0, 32'h44, 32'h40, 0,
             0, 32'h44, 1, 32'h800, 32'hFFFF_FFFE, 32'hFFFF_FFFE), 100);
    apply(mk(32'h40, BQ, 1, 32'h800, 0, 32'h44, 32'h40, 0,
             1, 32'h800, 1, 32'h800, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 101);
    apply(mk(32'h40, NB, 0, 0, 0, 0, 0, 0,
             1, 32'h800, 0, 32'h4, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 102);

    // Asynchronous reset in the middle of a pending taken update.
    @(posedge clk);
    #1;
    drive(mk(32'h40, BQ, 1, 32'h900, 0, 32'h64, 32'h60, 0,
             0, 0, 0, 0, 0, 0));
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst PredTakenF", 32'(bus.PredTakenF), 32'd0);
    chk("rst PredTargetF", bus.PredTargetF, 32'h44);
    chk("rst BranchCnt", bus.BranchCnt, 32'd0);
    chk("rst MispredCnt", bus.MispredCnt, 32'd0);
    @(posedge clk);
    #1;
    drive(mk(32'h40, NB, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("rst MispredictE", 32'(bus.MispredictE), 32'd0);
    rst_n = 1'b1;
    apply(mk(32'h40, NB, 0, 0, 0, 0, 0, 0,
             0, 32'h44, 0, 32'h4, 0, 0), 200);
    apply(mk(32'h60, NB, 0, 0, 0, 0, 0, 0,
             0, 32'h64, 0, 32'h4, 0, 0), 201);

    chk("scoreboard empty", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
